// File: rtl/ins_fetcher.sv
// rtl/ins_fetcher.sv - instruction fetch unit with optional direct-mapped I-cache (enabled by ICACHE_EN)
module ins_fetcher #(
   parameter logic [31:0] RESET_PC       = 32'h0,
   parameter int          ICACHE_IDX_BIT = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_addr,
   input  logic        is_stall,
   input  logic [31:0] next_PC,
   input  logic        rob_clear,
   input  logic [31:0] rob_new_pc,
   output logic        mc_req,
   output logic [31:0] mc_addr,
   input  logic        mc_done,
   input  logic [31:0] mc_data
);

   typedef enum logic [1:0] {
      S_LOOKUP,
      S_FETCH,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic        inst_valid_nx;
   logic [31:0] inst_nx, inst_addr_nx;
   logic        mc_req_nx;
   logic [31:0] mc_addr_nx;
   logic        lookup_hit;
   logic [31:0] lookup_data;

   // Redirect targets are word aligned; the byte-offset bits are dropped.
   logic unused_lsbs;
   assign unused_lsbs = ^{next_PC[1:0], rob_new_pc[1:0]};

`ifdef ICACHE_EN
   localparam int LINES = 1 << ICACHE_IDX_BIT;
   localparam int TAG_W = 30 - ICACHE_IDX_BIT;

   logic [LINES-1:0]          line_valid;
   logic [TAG_W-1:0]          line_tag  [LINES];
   logic [31:0]               line_data [LINES];
   logic [ICACHE_IDX_BIT-1:0] rd_idx, wr_idx;
   logic                      fill_en;

   // Fills always target the address still held on mc_addr, so a read that
   // completes after a flush lands on its own line rather than the new pc.
   assign rd_idx      = pc[ICACHE_IDX_BIT+1:2];
   assign wr_idx      = mc_addr[ICACHE_IDX_BIT+1:2];
   assign fill_en     = mc_done && (state == S_FETCH || state == S_DISCARD);
   assign lookup_hit  = line_valid[rd_idx] && (line_tag[rd_idx] == pc[31:ICACHE_IDX_BIT+2]);
   assign lookup_data = line_data[rd_idx];

   // Line valid bits: cleared by reset, set by each completed memory read.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         line_valid <= '0;
      end else if (rdy_in && fill_en) begin
         line_valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data arrays: written on fill only, no reset needed.
   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && fill_en) begin
         line_tag[wr_idx]  <= mc_addr[31:ICACHE_IDX_BIT+2];
         line_data[wr_idx] <= mc_data;
      end
   end
`else
   logic [31:0] unused_idx_cfg;
   assign unused_idx_cfg = ICACHE_IDX_BIT;
   assign lookup_hit     = 1'b0;
   assign lookup_data    = '0;
`endif

   // Fetch state and registered outputs; rdy_in low freezes everything.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state      <= S_LOOKUP;
         pc         <= RESET_PC;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_addr  <= '0;
         mc_req     <= 1'b0;
         mc_addr    <= '0;
      end else if (rdy_in) begin
         state      <= state_nx;
         pc         <= pc_nx;
         inst_valid <= inst_valid_nx;
         inst       <= inst_nx;
         inst_addr  <= inst_addr_nx;
         mc_req     <= mc_req_nx;
         mc_addr    <= mc_addr_nx;
      end
   end

   // Next-state and next-output logic; a flush is applied last so it wins.
   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      inst_valid_nx = inst_valid;
      inst_nx       = inst;
      inst_addr_nx  = inst_addr;
      mc_req_nx     = mc_req;
      mc_addr_nx    = mc_addr;

      case (state)
         S_LOOKUP: begin
            if (lookup_hit) begin
               inst_nx       = lookup_data;
               inst_addr_nx  = pc;
               inst_valid_nx = 1'b1;
               state_nx      = S_HOLD;
            end else begin
               mc_req_nx     = 1'b1;
               mc_addr_nx    = {pc[31:2], 2'b00};
               state_nx      = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mc_done) begin
               inst_nx       = mc_data;
               inst_addr_nx  = pc;
               inst_valid_nx = 1'b1;
               mc_req_nx     = 1'b0;
               state_nx      = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!is_stall) begin
               pc_nx         = {next_PC[31:2], 2'b00};
               inst_valid_nx = 1'b0;
               state_nx      = S_LOOKUP;
            end
         end
         S_DISCARD: begin
            if (mc_done) begin
               mc_req_nx     = 1'b0;
               state_nx      = S_LOOKUP;
            end
         end
         default: state_nx = S_LOOKUP;
      endcase

      if (rob_clear) begin
         pc_nx         = {rob_new_pc[31:2], 2'b00};
         inst_valid_nx = 1'b0;
         if (state == S_FETCH && !mc_done) begin
            // The read in flight must still complete; wait for it in DISCARD.
            state_nx   = S_DISCARD;
         end else if (state != S_DISCARD) begin
            state_nx   = S_LOOKUP;
            if (state == S_LOOKUP) begin
               mc_req_nx  = mc_req;
               mc_addr_nx = mc_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_ins_fetcher.sv
// tb/tb_ins_fetcher.sv - self-checking bench for ins_fetcher (vectors, corner sequences, random vs model)
module tb_ins_fetcher;

   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] C0     = 32'h0050_0093;
`ifdef ICACHE_EN
   localparam bit HAS_CACHE = 1'b1;
`else
   localparam bit HAS_CACHE = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, is_stall, rob_clear, mc_done;
   logic [31:0] next_PC, rob_new_pc, mc_data;
   logic        inst_valid, mc_req;
   logic [31:0] inst, inst_addr, mc_addr;

   ins_fetcher #(.RESET_PC(RST_PC), .ICACHE_IDX_BIT(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
      .is_stall(is_stall), .next_PC(next_PC),
      .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
      .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done), .mc_data(mc_data)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rdy, stall, done;
      logic [31:0] npc, data;
      logic        ev, er;
      logic [31:0] ei, ea, ema;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // reference model state for the random phase
   logic [31:0] m_pc, pend_addr;
   bit          pending, fetched, just_done, expect_invalid;
   int          lat, idle;
   bit          cv [16];
   logic [31:0] ca [16];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return C0;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic bit model_has(input logic [31:0] a);
      return HAS_CACHE && cv[a[5:2]] && (ca[a[5:2]] == a);
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC;
      else a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      return a | $urandom_range(0, 3);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic add(input logic rdy, stall, input logic [31:0] npc, input logic done,
                      input logic [31:0] data, input logic ev, input logic [31:0] ei, ea,
                      input logic er, input logic [31:0] ema);
      vec_t v;
      v.rdy = rdy; v.stall = stall; v.npc = npc; v.done = done; v.data = data;
      v.ev = ev; v.ei = ei; v.ea = ea; v.er = er; v.ema = ema;
      tbl.push_back(v);
   endtask

   // From HOLD: consume toward a, then expect either a hit or a memory read.
   task automatic fetch_to(input logic [31:0] a, input bit miss);
      is_stall = 1'b0; next_PC = a; step(); is_stall = 1'b1;
      chk("fetch.consume_drop", inst_valid, 0);
      step();
      if (miss) begin
         chk("fetch.req", mc_req, 1);
         chk("fetch.req_addr", mc_addr, a);
         mc_done = 1'b1; mc_data = mem_word(a); step(); mc_done = 1'b0;
      end else begin
         chk("fetch.no_req", mc_req, 0);
      end
      chk("fetch.valid", inst_valid, 1);
      chk("fetch.inst", inst, mem_word(a));
      chk("fetch.inst_addr", inst_addr, a);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; is_stall = 1'b1; next_PC = '0;
      rob_clear = 1'b0; rob_new_pc = '0; mc_done = 1'b0; mc_data = '0;
      step(); step();
      chk("reset.inst_valid", inst_valid, 0);
      chk("reset.inst", inst, 0);
      chk("reset.inst_addr", inst_addr, 0);
      chk("reset.mc_req", mc_req, 0);
      chk("reset.mc_addr", mc_addr, 0);

      // cold start, stall hold, rdy freeze, second fetch, re-access of 0
      add(1, 0, 0, 0, 0,              0, 0, 0, 1, 0);
      add(1, 0, 0, 0, 0,              0, 0, 0, 1, 0);
      add(1, 0, 0, 0, 0,              0, 0, 0, 1, 0);
      add(1, 0, 0, 1, C0,             1, C0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 1, C0, 0, 0, 0);
      add(0, 0, 8, 0, 0,              1, C0, 0, 0, 0);
      add(1, 0, 4, 0, 0,              0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0,              0, 0, 0, 1, 4);
      add(0, 0, 0, 0, 0,              0, 0, 0, 1, 4);
      add(1, 0, 0, 1, mem_word(4),    1, mem_word(4), 4, 0, 0);
      add(1, 0, 0, 0, 0,              0, 0, 0, 0, 0);
`ifdef ICACHE_EN
      add(1, 1, 0, 0, 0,              1, C0, 0, 0, 0);
`else
      add(1, 1, 0, 0, 0,              0, 0, 0, 1, 0);
      add(1, 1, 0, 1, C0,             1, C0, 0, 0, 0);
`endif
      add(1, 1, 0, 0, 0,              1, C0, 0, 0, 0);

      rst_in = 1'b1;
      foreach (tbl[i]) begin
         rdy_in = tbl[i].rdy; is_stall = tbl[i].stall; next_PC = tbl[i].npc;
         mc_done = tbl[i].done; mc_data = tbl[i].data;
         step();
         chk($sformatf("tbl[%0d].inst_valid", i), inst_valid, tbl[i].ev);
         chk($sformatf("tbl[%0d].mc_req", i), mc_req, tbl[i].er);
         if (tbl[i].ev) begin
            chk($sformatf("tbl[%0d].inst", i), inst, tbl[i].ei);
            chk($sformatf("tbl[%0d].inst_addr", i), inst_addr, tbl[i].ea);
         end
         if (tbl[i].er) chk($sformatf("tbl[%0d].mc_addr", i), mc_addr, tbl[i].ema);
      end
      rdy_in = 1'b1; is_stall = 1'b1; mc_done = 1'b0;

      // flush during a miss: read to 8 drains, then request for 0x100
      is_stall = 1'b0; next_PC = 32'h8; step(); is_stall = 1'b1;
      step();
      chk("fmiss.req", mc_req, 1);
      chk("fmiss.addr", mc_addr, 32'h8);
      rob_clear = 1'b1; rob_new_pc = 32'h100; step(); rob_clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fmiss.req_held", mc_req, 1);
         chk("fmiss.addr_held", mc_addr, 32'h8);
         chk("fmiss.no_valid", inst_valid, 0);
         if (i < 2) step();
      end
      mc_done = 1'b1; mc_data = mem_word(32'h8); step(); mc_done = 1'b0;
      chk("fmiss.drop_valid", inst_valid, 0);
      chk("fmiss.drop_req", mc_req, 0);
      step();
      chk("fmiss.new_req", mc_req, 1);
      chk("fmiss.new_addr", mc_addr, 32'h100);
      mc_done = 1'b1; mc_data = mem_word(32'h100); step(); mc_done = 1'b0;
      chk("fmiss.valid", inst_valid, 1);
      chk("fmiss.inst_addr", inst_addr, 32'h100);
      chk("fmiss.inst", inst, mem_word(32'h100));

      // flush wins over a simultaneous consume; misaligned target is aligned
      is_stall = 1'b0; next_PC = 32'h4; rob_clear = 1'b1; rob_new_pc = 32'h203;
      step(); is_stall = 1'b1; rob_clear = 1'b0;
      chk("prio.valid", inst_valid, 0);
      chk("prio.req_idle", mc_req, 0);
      step();
      chk("prio.req", mc_req, 1);
      chk("prio.addr", mc_addr, 32'h200);
      mc_done = 1'b1; mc_data = mem_word(32'h200); step(); mc_done = 1'b0;
      chk("prio.inst_addr", inst_addr, 32'h200);

      // index conflict: 0, 0x40, 0 all miss; 4 still resident
      fetch_to(32'h0, 1'b1);
      fetch_to(32'h40, 1'b1);
      fetch_to(32'h0, 1'b1);
      fetch_to(32'h4, !HAS_CACHE);

      // reset in the middle of a read; cache must be cold afterwards
      is_stall = 1'b0; next_PC = 32'h300; step(); is_stall = 1'b1;
      step();
      chk("rstf.req", mc_req, 1);
      rst_in = 1'b0; step();
      chk("rstf.req_drop", mc_req, 0);
      chk("rstf.addr_clr", mc_addr, 0);
      chk("rstf.valid", inst_valid, 0);
      rst_in = 1'b1; step();
      chk("rstf.req_reset_pc", mc_req, 1);
      chk("rstf.addr_reset_pc", mc_addr, RST_PC);

      // random phase against the transaction-level model
      rst_in = 1'b0; step(); step(); rst_in = 1'b1;
      m_pc = RST_PC; pending = 0; fetched = 0; just_done = 0; expect_invalid = 0;
      lat = 0; idle = 0;
      foreach (cv[i]) cv[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (expect_invalid) chk("rnd.dropped", inst_valid, 0);
         if (just_done) chk("rnd.req_gap", mc_req, 0);
         just_done = 0; expect_invalid = 0;
         if (mc_req && !pending) begin
            chk("rnd.req_addr", mc_addr, m_pc);
            chk("rnd.req_on_miss", model_has(m_pc), 0);
            pending = 1; pend_addr = mc_addr; lat = $urandom_range(0, 3);
            fetched = 1; idle = 0;
         end
         if (inst_valid) begin
            chk("rnd.inst_addr", inst_addr, m_pc);
            chk("rnd.inst", inst, mem_word(m_pc));
            chk("rnd.source", fetched || model_has(m_pc), 1);
            chk("rnd.req_while_valid", mc_req, 0);
            idle = 0;
         end

         rdy_in = ($urandom_range(0, 9) != 0);
         mc_done = 1'b0; rob_clear = 1'b0; is_stall = 1'b1;
         next_PC = rand_addr(); rob_new_pc = rand_addr(); mc_data = $urandom;
         if (!rdy_in) begin
            is_stall = $urandom_range(0, 1);
            rob_clear = $urandom_range(0, 1);
         end else begin
            if (pending) begin
               if (lat == 0) begin
                  mc_done = 1'b1; mc_data = mem_word(pend_addr);
                  if (HAS_CACHE) begin
                     cv[pend_addr[5:2]] = 1; ca[pend_addr[5:2]] = pend_addr;
                  end
                  pending = 0; just_done = 1; idle = 0;
               end else begin
                  lat--;
               end
            end
            if (!mc_done && $urandom_range(0, 19) == 0) begin
               rob_clear = 1'b1; m_pc = {rob_new_pc[31:2], 2'b00};
               fetched = 0; expect_invalid = 1;
            end else if (inst_valid) begin
               is_stall = ($urandom_range(0, 2) == 0);
               if (!is_stall) begin
                  m_pc = {next_PC[31:2], 2'b00}; fetched = 0; expect_invalid = 1;
               end
            end else begin
               is_stall = $urandom_range(0, 1);
            end
         end
         if (idle > 80) begin
            chk("rnd.watchdog", idle, 0);
            break;
         end
         step();
         idle++;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
